// File: rtl/wd_apb_slave_if.sv
// APB bus bundle between the initiator (testbench driver) and the watchdog completer.
// Carries the select, phase, address and data signals plus the completer's response.
interface wd_apb_slave_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/wd_apb_slave.sv
// Watchdog timer behind a zero-wait-state 8-bit APB completer.
// A prescaled down-counter raises intr on the first expiry and timeout on a second, unserviced one.
module wd_apb_slave #(
  parameter int         PRESCALE = 4,
  parameter logic [7:0] LOAD_RST = 8'hFF,
  parameter logic [7:0] KICK_KEY = 8'h5A
) (
  input  logic                pclk,
  input  logic                preset,
  wd_apb_slave_if.slave       apb,
  output logic                timeout,
  output logic                intr
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_LOAD   = 8'h01;
  localparam logic [7:0] A_COUNT  = 8'h02;
  localparam logic [7:0] A_KICK   = 8'h03;
  localparam logic [7:0] A_STATUS = 8'h04;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t        r_state;
  logic [7:0]    r_addr;
  logic [7:0]    r_wdata;
  logic          r_write;
  logic [7:0]    r_prdata;
  logic          r_pready;
  logic          r_pslverr;

  logic [2:0]    r_ctrl;
  logic [7:0]    r_load;
  logic [7:0]    r_count;
  logic [PW-1:0] r_presc;
  logic          r_pend;
  logic          r_timeout;
  logic          r_intr;

  logic [7:0]    w_rdata;
  logic          w_commit;
  logic          w_kick;
  logic          w_en_rise;
  logic          w_tick;
  logic          w_expire;
  logic [2:0]    w_ctrl_nxt;
  logic [7:0]    w_load_nxt;
  logic [7:0]    w_count_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic          w_pend_nxt;
  logic          w_timeout_nxt;

  function automatic logic addr_decoded(input logic [7:0] addr);
    return (addr <= A_STATUS);
  endfunction

  assign apb.prdata  = r_prdata;
  assign apb.pready  = r_pready;
  assign apb.pslverr = r_pslverr;
  assign timeout     = r_timeout;
  assign intr        = r_intr;

  always_comb begin
    w_rdata = 8'h00;
    case (apb.paddr)
      A_CTRL:   w_rdata = {5'b00000, r_ctrl};
      A_LOAD:   w_rdata = r_load;
      A_COUNT:  w_rdata = r_count;
      A_KICK:   w_rdata = 8'h00;
      A_STATUS: w_rdata = {6'b000000, r_timeout, r_pend};
      default:  w_rdata = 8'h00;
    endcase
  end

  // Writes latched on entry to ACCESS take effect at the edge that ends ACCESS.
  always_comb begin
    w_commit      = (r_state == S_ACCESS) && r_write;
    w_kick        = w_commit && (r_addr == A_KICK) && (r_wdata == KICK_KEY);
    w_en_rise     = w_commit && (r_addr == A_CTRL) && r_wdata[0] && !r_ctrl[0];
    w_tick        = r_ctrl[0] && (r_presc == PRESC_MAX);
    w_expire      = w_tick && (r_count == 8'h00) && !w_kick;
    w_ctrl_nxt    = (w_commit && (r_addr == A_CTRL)) ? r_wdata[2:0] : r_ctrl;
    w_load_nxt    = (w_commit && (r_addr == A_LOAD)) ? r_wdata : r_load;
    w_count_nxt   = r_count;
    w_presc_nxt   = r_presc;
    if (w_kick || w_en_rise) begin
      w_count_nxt = r_load;
      w_presc_nxt = '0;
    end else if (r_ctrl[0]) begin
      w_presc_nxt = w_tick ? '0 : (r_presc + PW'(1));
      if (w_tick) begin
        w_count_nxt = (r_count == 8'h00) ? r_load : (r_count - 8'd1);
      end else begin
        w_count_nxt = r_count;
      end
    end else begin
      w_count_nxt = r_count;
    end
    // An expiry that sets intr_pend overrides a same-cycle write-1-to-clear.
    if (w_expire && !(r_pend && r_ctrl[2])) begin
      w_pend_nxt = 1'b1;
    end else if (w_commit && (r_addr == A_STATUS) && r_wdata[0]) begin
      w_pend_nxt = 1'b0;
    end else begin
      w_pend_nxt = r_pend;
    end
    w_timeout_nxt = r_timeout | (w_expire && r_pend && r_ctrl[2]);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state   <= S_IDLE;
      r_addr    <= 8'h00;
      r_wdata   <= 8'h00;
      r_write   <= 1'b0;
      r_prdata  <= 8'h00;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (apb.psel && !apb.penable) begin
            r_state <= S_SETUP;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SETUP: begin
          if (!apb.psel) begin
            r_state <= S_IDLE;
          end else if (apb.penable) begin
            r_state   <= S_ACCESS;
            r_pready  <= 1'b1;
            r_pslverr <= !addr_decoded(apb.paddr);
            r_addr    <= apb.paddr;
            r_wdata   <= apb.pwdata;
            r_write   <= apb.pwrite;
            if (!apb.pwrite) begin
              r_prdata <= w_rdata;
            end else begin
              r_prdata <= r_prdata;
            end
          end else begin
            r_state <= S_SETUP;
          end
        end
        S_ACCESS: begin
          if (apb.psel && !apb.penable) begin
            r_state <= S_SETUP;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_ctrl    <= 3'b000;
      r_load    <= LOAD_RST;
      r_count   <= 8'hFF;
      r_presc   <= '0;
      r_pend    <= 1'b0;
      r_timeout <= 1'b0;
      r_intr    <= 1'b0;
    end else begin
      r_ctrl    <= w_ctrl_nxt;
      r_load    <= w_load_nxt;
      r_count   <= w_count_nxt;
      r_presc   <= w_presc_nxt;
      r_pend    <= w_pend_nxt;
      r_timeout <= w_timeout_nxt;
      r_intr    <= w_pend_nxt & w_ctrl_nxt[1];
    end
  end

endmodule

// File: doc/wd_apb_slave.md
Name: wd_apb_slave

Overview:
- APB completer that hosts the watchdog timer: the responder end of the 8-bit APB bus that the testbench driver initiates.
- Decodes register accesses, runs a prescaled down-counter and raises `intr` on the first expiry.
- Raises `timeout` if a second expiry occurs while the interrupt is still pending.
- Sits between the APB fabric and the system reset/interrupt controller.

Parameters:
- PRESCALE, 4, pclk cycles per counter tick (>=1)
- LOAD_RST, 8'hFF, reset value of LOAD register
- KICK_KEY, 8'h5A, value that must be written to KICK to reload the counter

Ports:
- pclk  in  1  clock
- preset  in  1  reset; synchronous, active-high
- psel  in  1  APB select
- penable  in  1  APB access phase
- pwrite  in  1  1=write, 0=read
- paddr  in  8  register address
- pwdata  in  8  write data
- prdata  out  8  read data, valid in access phase
- pready  out  1  transfer complete
- pslverr  out  1  error on undecoded address
- timeout  out  1  watchdog reset request (sticky)
- intr  out  1  watchdog interrupt (level)

Behaviour:
- Decided: one clock; reset is synchronous and active-high.
- At reset (preset=1 at posedge), all state clears:
  - Outputs: prdata=0, pready=0, pslverr=0, timeout=0, intr=0.
  - Registers: CTRL=0, LOAD=LOAD_RST, COUNT=8'hFF, prescaler=0, intr_pend=0.
  - APB FSM returns to IDLE, including mid-transfer.
- APB FSM has three states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP on psel=1, penable=0.
  - SETUP holds while psel=1, penable=0. Setup may last any number of cycles; the initiator can insert delay cycles before penable.
  - SETUP -> ACCESS on psel=1, penable=1.
  - ACCESS -> IDLE after one cycle, or -> SETUP if psel=1, penable=0.
  - psel=0 in any state -> IDLE.
  - penable=1 without a preceding SETUP is ignored; no register effect.
- Timing: zero wait states.
  - pready is registered: 1 for exactly the cycle after SETUP sees penable rise, i.e. the ACCESS cycle. It is 0 otherwise.
  - prdata is registered when entering ACCESS and is held until the next read. The initiator samples it at the posedge ending ACCESS.
  - Writes commit at the posedge ending ACCESS.
  - pslverr=1 alongside pready for undecoded addresses. Undecoded reads return 0; undecoded writes are dropped.
- Register map:
  - 0x00 CTRL, RW: [0] EN, [1] INTR_EN, [2] RST_EN; [7:3] read 0.
  - 0x01 LOAD, RW: reload value.
  - 0x02 COUNT, RO: current count. Writes are ignored with no error.
  - 0x03 KICK, WO: writing KICK_KEY reloads COUNT from LOAD and clears the prescaler. Other values have no effect. Reads return 0.
  - 0x04 STATUS: [0] intr_pend, write-1-to-clear; [1] timeout, RO.
- Counter:
  - A write of EN 0->1 loads COUNT=LOAD and clears the prescaler.
  - While EN=1 the prescaler counts 0..PRESCALE-1 and emits a tick when it wraps.
  - On a tick with COUNT!=0: COUNT decrements by 1.
  - On a tick with COUNT==0 (expiry): COUNT reloads from LOAD. If intr_pend=1 and RST_EN=1, timeout sets; otherwise intr_pend sets.
  - LOAD=0 expires on every tick.
  - EN=0 freezes COUNT and the prescaler.
- Outputs:
  - intr = intr_pend & INTR_EN, registered.
  - timeout is sticky and clears only on preset.
- Simultaneous events:
  - Kick and tick in the same cycle: kick wins; no decrement or expiry.
  - STATUS W1C and expiry setting intr_pend in the same cycle: set wins.
  - LOAD write and reload in the same cycle: the reload uses the old LOAD.

Test Plan:
- Reset, then read every address -> CTRL=0x00, LOAD=0xFF, COUNT=0xFF, STATUS=0x00, 0x05 reads 0 with pslverr=1; pready high exactly 1 cycle per access.
- Write LOAD=0x03, CTRL=0x03, PRESCALE=4 -> COUNT reads 3,2,1,0 at 4-cycle spacing; intr rises within 1 cycle after the 4th tick; COUNT returns to 3.
- Run with KICK=0x5A every 10 cycles (LOAD=3) -> intr never asserts. KICK=0x11 -> no reload; expiry occurs.
- CTRL=0x07, LOAD=0x01, no service -> first expiry sets intr; second expiry sets timeout=1 and STATUS=0x03. STATUS W1C 0x01 clears intr; timeout stays until preset.
- Read with 3 setup cycles before penable -> no premature pready; correct prdata in ACCESS. preset=1 during SETUP -> next transfer completes normally.
- Write STATUS=0x01 on the exact expiry cycle -> intr_pend remains 1. Kick on a tick cycle -> COUNT=LOAD with no decrement.
